// File: rtl/sal_rd_pkg.sv
// Shared types and width helpers for the read-response path.
// Descriptor layout is fixed by the package widths below.
package sal_rd_pkg;
  localparam int SAL_ID_W  = 4;
  localparam int SAL_LEN_W = 4;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef struct packed {
    logic [SAL_ID_W-1:0]  id;
    logic [SAL_LEN_W-1:0] len;
  } rd_desc_t;

  function automatic int acc_w(input int depth);
    return $clog2(depth) + 2;
  endfunction
endpackage

// File: rtl/sal_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty differ.
module sal_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        full;

  always_comb begin
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = (wr_q == rd_q);
    count = wr_q - rd_q;
    dout  = mem_q[rd_q[AW-1:0]];
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) wr_d = wr_q + ONE;
    if (pop && !empty) rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/sal_rd_resp_gen.sv
// AXI read-response generator: buffers DFI beats and pairs them
// with posted descriptors; admits commands only with room reserved.
module sal_rd_resp_gen
  import sal_rd_pkg::*;
#(
  parameter int ID_WIDTH   = SAL_ID_W,
  parameter int LEN_WIDTH  = SAL_LEN_W,
  parameter int DATA_WIDTH = 128,
  parameter int CMD_DEPTH  = 8,
  parameter int DATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ID_WIDTH-1:0]   rd_cmd_id,
  input  logic [LEN_WIDTH-1:0]  rd_cmd_len,
  input  logic                  dfi_rddata_valid,
  input  logic [DATA_WIDTH-1:0] dfi_rddata,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  err_overflow,
  output logic                  err_orphan
);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int DA = $clog2(DATA_DEPTH);
  localparam int CW = acc_w(DATA_DEPTH);
  localparam logic [CA:0] CMD_FULL_C  = CMD_DEPTH[CA:0];
  localparam logic [DA:0] DATA_FULL_C = DATA_DEPTH[DA:0];
  localparam logic [CW-1:0] DEPTH_C   = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] ONE_C     = 1;
  localparam logic [LEN_WIDTH-1:0] BONE = 1;

  rd_desc_t    cmd_din, cmd_head;
  logic        cmd_empty, cmd_full;
  logic [CA:0] cmd_count;
  logic [DATA_WIDTH-1:0] data_head;
  logic        data_empty, data_full;
  logic [DA:0] data_count;

  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] committed, need;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic err_overflow_q, err_overflow_d;
  logic err_orphan_q, err_orphan_d;
  logic cmd_fire, beat_push, r_fire;

  always_comb begin
    cmd_din    = '{id: rd_cmd_id, len: rd_cmd_len};
    cmd_full   = (cmd_count == CMD_FULL_C);
    data_full  = (data_count == DATA_FULL_C);
    committed  = CW'(data_count) + pending_q;
    need       = committed + CW'(rd_cmd_len) + ONE_C;
    // Ready is held low while rst is asserted.
    rd_cmd_ready = !rst && !cmd_full && (need <= DEPTH_C);
    cmd_fire   = rd_cmd_valid && rd_cmd_ready;
    beat_push  = dfi_rddata_valid && (pending_q != '0) && !data_full;
    axi_rvalid = !data_empty && !cmd_empty;
    axi_rid    = cmd_head.id;
    axi_rdata  = data_head;
    axi_rresp  = RRESP_OKAY;
    axi_rlast  = axi_rvalid && (beat_cnt_q == cmd_head.len);
    r_fire     = axi_rvalid && axi_rready;

    pending_d = pending_q;
    if (cmd_fire)
      pending_d = pending_d + CW'(rd_cmd_len) + ONE_C;
    if (dfi_rddata_valid && (pending_q != '0))
      pending_d = pending_d - ONE_C;

    beat_cnt_d = beat_cnt_q;
    if (r_fire)
      beat_cnt_d = axi_rlast ? '0 : beat_cnt_q + BONE;

    err_orphan_d   = err_orphan_q ||
                     (dfi_rddata_valid && (pending_q == '0));
    err_overflow_d = err_overflow_q ||
                     (dfi_rddata_valid && (pending_q != '0) && data_full);
    err_overflow   = err_overflow_q;
    err_orphan     = err_orphan_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      beat_cnt_q     <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      beat_cnt_q     <= beat_cnt_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  sal_sync_fifo #(
    .WIDTH($bits(rd_desc_t)),
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_fire),
    .din  (cmd_din),
    .pop  (r_fire && axi_rlast),
    .dout (cmd_head),
    .empty(cmd_empty),
    .count(cmd_count)
  );

  sal_sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(DATA_DEPTH)
  ) u_data_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (beat_push),
    .din  (dfi_rddata),
    .pop  (r_fire),
    .dout (data_head),
    .empty(data_empty),
    .count(data_count)
  );
endmodule

// File: tb/tb_sal_rd_resp_gen.sv
// Directed bench for sal_rd_resp_gen: vector table plus
// hand-written multi-cycle sequences with a response scoreboard.
module tb_sal_rd_resp_gen;
  logic         clk = 1'b0;
  logic         rst;
  logic         rd_cmd_valid, rd_cmd_ready;
  logic [3:0]   rd_cmd_id, rd_cmd_len;
  logic         dfi_rddata_valid;
  logic [127:0] dfi_rddata;
  logic         axi_rvalid, axi_rready;
  logic [3:0]   axi_rid;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast, err_overflow, err_orphan;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sal_rd_resp_gen dut (
    .clk             (clk),
    .rst             (rst),
    .rd_cmd_valid    (rd_cmd_valid),
    .rd_cmd_ready    (rd_cmd_ready),
    .rd_cmd_id       (rd_cmd_id),
    .rd_cmd_len      (rd_cmd_len),
    .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_rddata      (dfi_rddata),
    .axi_rvalid      (axi_rvalid),
    .axi_rready      (axi_rready),
    .axi_rid         (axi_rid),
    .axi_rdata       (axi_rdata),
    .axi_rresp       (axi_rresp),
    .axi_rlast       (axi_rlast),
    .err_overflow    (err_overflow),
    .err_orphan      (err_orphan)
  );

  typedef struct {
    logic cv; logic [3:0] id; logic [3:0] len;
    logic dv; logic [127:0] d; logic rr;
    logic e_rdy; logic e_rv; logic [3:0] e_id;
    logic [127:0] e_d; logic e_last;
  } vec_t;

  typedef struct {
    logic [3:0] id; logic [127:0] d; logic last;
  } exp_t;

  vec_t vt [16];
  exp_t exp_q [$];

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drv(input logic cv, input logic [3:0] id,
                     input logic [3:0] len, input logic dv,
                     input logic [127:0] d, input logic rr);
    rd_cmd_valid = cv;
    rd_cmd_id = id;
    rd_cmd_len = len;
    dfi_rddata_valid = dv;
    dfi_rddata = d;
    axi_rready = rr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_burst(input logic [3:0] id,
                            input int len, input int base);
    for (int k = 0; k <= len; k++)
      exp_q.push_back('{id, 128'(base + k), k == len});
  endtask

  task automatic feed(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drv(0, 0, 0, 1, 128'(base + k), 0);
    end
  endtask

  task automatic drain(input int n);
    int got = 0;
    int cyc = 0;
    exp_t e;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      rd_cmd_valid = 0;
      dfi_rddata_valid = 0;
      axi_rready = 1;
      #1;
      if (axi_rvalid) begin
        e = exp_q.pop_front();
        chk("drain_rid", 128'(axi_rid), 128'(e.id));
        chk("drain_rdata", axi_rdata, e.d);
        chk("drain_rlast", 128'(axi_rlast), 128'(e.last));
        chk("drain_rresp", 128'(axi_rresp), 128'd0);
        got++;
      end
      cyc++;
    end
    if (got < n) begin
      errs++;
      checks++;
      $display("FAIL drain_timeout: got %0d beats expected %0d",
               got, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);

    vt[0]  = '{1,3,3,0,0,1,     1,0,0,0,0};
    vt[1]  = '{0,0,0,1,'hD0,1,  1,0,0,0,0};
    vt[2]  = '{0,0,0,1,'hD1,1,  1,1,3,'hD0,0};
    vt[3]  = '{0,0,0,1,'hD2,1,  1,1,3,'hD1,0};
    vt[4]  = '{0,0,0,1,'hD3,1,  1,1,3,'hD2,0};
    vt[5]  = '{0,0,0,0,0,1,     1,1,3,'hD3,1};
    vt[6]  = '{0,0,0,0,0,1,     1,0,0,0,0};
    vt[7]  = '{1,1,1,0,0,0,     1,0,0,0,0};
    vt[8]  = '{1,2,0,0,0,0,     1,0,0,0,0};
    vt[9]  = '{0,0,0,1,'hE0,0,  1,0,0,0,0};
    vt[10] = '{0,0,0,1,'hE1,0,  1,1,1,'hE0,0};
    vt[11] = '{0,0,0,1,'hE2,0,  1,1,1,'hE0,0};
    vt[12] = '{0,0,0,0,0,1,     1,1,1,'hE0,0};
    vt[13] = '{0,0,0,0,0,1,     1,1,1,'hE1,1};
    vt[14] = '{0,0,0,0,0,1,     1,1,2,'hE2,1};
    vt[15] = '{0,0,0,0,0,1,     1,0,0,0,0};

    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 128'(rd_cmd_ready), 128'd0);
    chk("rst_rvalid", 128'(axi_rvalid), 128'd0);
    chk("rst_rlast", 128'(axi_rlast), 128'd0);
    chk("rst_errs", 128'({err_overflow, err_orphan}), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drv(vt[i].cv, vt[i].id, vt[i].len,
          vt[i].dv, vt[i].d, vt[i].rr);
      #1;
      chk($sformatf("v%0d_ready", i),
          128'(rd_cmd_ready), 128'(vt[i].e_rdy));
      chk($sformatf("v%0d_rvalid", i),
          128'(axi_rvalid), 128'(vt[i].e_rv));
      chk($sformatf("v%0d_rlast", i),
          128'(axi_rlast), 128'(vt[i].e_last));
      if (vt[i].e_rv) begin
        chk($sformatf("v%0d_rid", i),
            128'(axi_rid), 128'(vt[i].e_id));
        chk($sformatf("v%0d_rdata", i), axi_rdata, vt[i].e_d);
      end
    end

    // Backpressure: two full bursts fill the buffer.
    do_reset();
    drv(1, 5, 15, 0, 0, 0);
    #1 chk("bp_rdy1", 128'(rd_cmd_ready), 128'd1);
    @(negedge clk);
    drv(1, 6, 15, 0, 0, 0);
    #1 chk("bp_rdy2", 128'(rd_cmd_ready), 128'd1);
    @(negedge clk);
    drv(1, 7, 0, 0, 0, 0);
    #1 chk("bp_rdy3", 128'(rd_cmd_ready), 128'd0);
    feed(6000, 32);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("bp_full_rvalid", 128'(axi_rvalid), 128'd1);
    chk("bp_full_rdy", 128'(rd_cmd_ready), 128'd0);
    chk("bp_no_ovf", 128'(err_overflow), 128'd0);
    push_burst(5, 15, 6000);
    push_burst(6, 15, 6016);
    drain(1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("bp_rdy_len0", 128'(rd_cmd_ready), 128'd1);
    rd_cmd_len = 15;
    #1 chk("bp_rdy_len15", 128'(rd_cmd_ready), 128'd0);
    drain(31);
    @(negedge clk);
    drv(0, 0, 15, 0, 0, 0);
    #1;
    chk("bp_rdy_empty", 128'(rd_cmd_ready), 128'd1);
    chk("bp_errs", 128'({err_overflow, err_orphan}), 128'd0);

    // Accept and beat in one cycle: net pending += len.
    do_reset();
    drv(1, 1, 3, 0, 0, 0);
    @(negedge clk);
    drv(1, 2, 7, 1, 128'd5000, 0);
    @(negedge clk);
    drv(1, 3, 15, 0, 0, 0);
    #1 chk("sim_rdy_len15", 128'(rd_cmd_ready), 128'd1);
    @(negedge clk);
    drv(0, 0, 3, 0, 0, 0);
    #1 chk("sim_rdy_len3", 128'(rd_cmd_ready), 128'd1);
    rd_cmd_len = 4;
    #1 chk("sim_rdy_len4", 128'(rd_cmd_ready), 128'd0);
    feed(5001, 27);
    push_burst(1, 3, 5000);
    push_burst(2, 7, 5004);
    push_burst(3, 15, 5012);
    drain(28);

    // Orphan beat.
    do_reset();
    drv(0, 0, 0, 1, 128'hBAD, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 1);
    #1;
    chk("orph_flag", 128'(err_orphan), 128'd1);
    chk("orph_rvalid", 128'(axi_rvalid), 128'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("orph_sticky", 128'(err_orphan), 128'd1);
    chk("orph_rvalid2", 128'(axi_rvalid), 128'd0);
    do_reset();
    #1 chk("orph_cleared", 128'(err_orphan), 128'd0);

    // Reset mid-burst, then a fresh single-beat read.
    drv(1, 4, 3, 0, 0, 0);
    feed(7000, 4);
    push_burst(4, 3, 7000);
    drain(2);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 15, 0, 0, 0);
    #1;
    chk("mid_rvalid", 128'(axi_rvalid), 128'd0);
    chk("mid_empty_rdy", 128'(rd_cmd_ready), 128'd1);
    exp_q.delete();
    @(negedge clk);
    drv(1, 9, 0, 0, 0, 0);
    feed(7100, 1);
    push_burst(9, 0, 7100);
    drain(1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("mid_done_rvalid", 128'(axi_rvalid), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
